// File: rtl/tankb_input_cond.sv
// Input conditioning for the Tank Battalion CONTROLS bus: sync, debounce, direction
// cancelling and coin-pulse shaping, producing an active-low control vector.
module tankb_input_cond #(
    parameter int TICK_DIV   = 18000,
    parameter int DEB_TICKS  = 4,
    parameter int COIN_PULSE = 50,
    parameter int COIN_GAP   = 100
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [8:0]  joy_in,
    input  logic        test_sw,
    output logic [9:0]  controls_n,
    output logic        coin_busy,
    output logic [15:0] coin_total
);

    localparam logic [15:0] TICK_LAST  = 16'(TICK_DIV - 1);
    localparam logic [3:0]  DEB_LAST   = 4'(DEB_TICKS - 1);
    localparam logic [7:0]  PULSE_LOAD = 8'(COIN_PULSE - 1);
    localparam logic [7:0]  GAP_LOAD   = 8'(COIN_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } coin_state_t;

    logic [15:0]  r_tick_cnt;
    logic         w_tick;
    logic [9:0]   r_sync1;
    logic [9:0]   r_sync2;
    logic [8:0]   w_db;
    logic         w_right;
    logic         w_left;
    logic         w_down;
    logic         w_up;
    logic         r_coin_prev;
    logic         w_coin_rise;
    logic [1:0]   r_pending;
    logic [1:0]   w_pending_next;
    coin_state_t  r_state;
    coin_state_t  w_state_next;
    logic [7:0]   r_timer;
    logic [7:0]   w_timer_next;
    logic         w_take;
    logic [15:0]  r_coin_total;
    logic [9:0]   r_controls_n;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
        end
    end

    // test_sw rides along as bit 9 of the synchroniser
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {test_sw, joy_in};
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_deb
            logic [3:0] r_cnt;
            logic       r_val;

            always_ff @(posedge clk_sys or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_val <= 1'b0;
                end else if (w_tick) begin
                    if (r_sync2[gi] != r_val) begin
                        if (r_cnt == DEB_LAST) begin
                            r_val <= r_sync2[gi];
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            assign w_db[gi] = r_val;
        end
    endgenerate

    // Opposing directions cancel each other rather than letting one win
    assign w_right = w_db[0] & ~w_db[1];
    assign w_left  = w_db[1] & ~w_db[0];
    assign w_down  = w_db[2] & ~w_db[3];
    assign w_up    = w_db[3] & ~w_db[2];

    assign w_coin_rise = w_db[7] & ~r_coin_prev;

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_take       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending != 2'd0) begin
                    w_take       = 1'b1;
                    w_state_next = S_PULSE;
                    w_timer_next = PULSE_LOAD;
                end
            end
            S_PULSE: begin
                if (w_tick) begin
                    if (r_timer == 8'd0) begin
                        w_state_next = S_GAP;
                        w_timer_next = GAP_LOAD;
                    end else begin
                        w_timer_next = r_timer - 8'd1;
                    end
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    if (r_timer == 8'd0) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_timer_next = r_timer - 8'd1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // An edge arriving on the same clock as a credit is consumed leaves the count unchanged
    always_comb begin
        w_pending_next = r_pending;
        if (w_coin_rise && !w_take) begin
            if (r_pending != 2'd3) begin
                w_pending_next = r_pending + 2'd1;
            end
        end else if (!w_coin_rise && w_take) begin
            w_pending_next = r_pending - 2'd1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_pending    <= '0;
            r_coin_prev  <= 1'b0;
            r_coin_total <= '0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_pending   <= w_pending_next;
            r_coin_prev <= w_db[7];
            if (w_take) begin
                r_coin_total <= r_coin_total + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_controls_n <= 10'h3FF;
        end else begin
            r_controls_n <= ~{w_db[8], r_sync2[9], (r_state == S_PULSE), w_db[6], w_db[5],
                              w_db[4], w_up, w_down, w_left, w_right};
        end
    end

    assign controls_n = r_controls_n;
    assign coin_busy  = (r_state != S_IDLE);
    assign coin_total = r_coin_total;

endmodule

// File: tb/tb_tankb_input_cond.sv
// Bench for tankb_input_cond: vector table, directed coin/reset sequences and a
// randomized run checked every cycle against a tick/credit-level reference model.
module tb_tankb_input_cond;

    localparam int TD = 4;
    localparam int DT = 2;
    localparam int CP = 3;
    localparam int CG = 2;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [8:0]  joy_in;
    logic        test_sw;
    logic [9:0]  controls_n;
    logic        coin_busy;
    logic [15:0] coin_total;

    tankb_input_cond #(
        .TICK_DIV  (TD),
        .DEB_TICKS (DT),
        .COIN_PULSE(CP),
        .COIN_GAP  (CG)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .joy_in    (joy_in),
        .test_sw   (test_sw),
        .controls_n(controls_n),
        .coin_busy (coin_busy),
        .coin_total(coin_total)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d..%0d", name, $time, act, lo, hi);
        end
    endtask

    // Reference model: ticks from an edge count, input history, per-bit disagreement
    // streaks, and a credit queue served as pulse/gap tick budgets.
    int          m_cyc;
    logic [9:0]  m_s1, m_s2;
    logic [8:0]  m_db;
    int          m_streak [9];
    logic        m_prev;
    int          m_wait;
    int          m_pulse_left, m_gap_left;
    logic [15:0] m_total;
    logic [9:0]  m_ctrl;
    int          m_drops;

    task automatic model_clear();
        m_cyc = 0; m_s1 = '0; m_s2 = '0; m_db = '0; m_prev = 1'b0;
        for (int i = 0; i < 9; i++) m_streak[i] = 0;
        m_wait = 0; m_pulse_left = 0; m_gap_left = 0; m_total = '0; m_ctrl = 10'h3FF;
    endtask

    task automatic model_step();
        bit tick, rise, start;
        logic [9:0] n_ctrl;
        if (reset) begin
            model_clear();
            return;
        end
        tick = ((m_cyc % TD) == TD - 1);
        n_ctrl = ~{m_db[8], m_s2[9], (m_pulse_left > 0), m_db[6], m_db[5], m_db[4],
                   m_db[3] & ~m_db[2], m_db[2] & ~m_db[3], m_db[1] & ~m_db[0], m_db[0] & ~m_db[1]};
        rise  = m_db[7] && !m_prev;
        start = (m_pulse_left == 0 && m_gap_left == 0 && m_wait > 0);
        m_prev = m_db[7];
        if (tick) begin
            for (int i = 0; i < 9; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_streak[i]++;
                    if (m_streak[i] >= DT) begin
                        m_db[i] = m_s2[i];
                        m_streak[i] = 0;
                    end
                end else begin
                    m_streak[i] = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = {test_sw, joy_in};
        if (start) begin
            m_pulse_left = CP;
            m_total++;
        end else if (m_pulse_left > 0 && tick) begin
            m_pulse_left--;
            if (m_pulse_left == 0) m_gap_left = CG;
        end else if (m_gap_left > 0 && tick) begin
            m_gap_left--;
        end
        if (rise && !start) begin
            if (m_wait == 3) m_drops++;
            else m_wait++;
        end else if (!rise && start) begin
            m_wait--;
        end
        m_ctrl = n_ctrl;
        m_cyc++;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk("model_ctrl", 32'(controls_n), 32'(m_ctrl));
        chk("model_busy", 32'(coin_busy), 32'((m_pulse_left > 0) || (m_gap_left > 0)));
        chk("model_total", 32'(coin_total), 32'(m_total));
    endtask

    // Coin-output monitor
    int   mon_pulses, mon_low_run, mon_high_run, mon_min_w, mon_max_w, mon_min_gap, mon_busy;
    logic mon_prev_low;

    task automatic mon_reset();
        mon_pulses = 0; mon_low_run = 0; mon_high_run = 0; mon_min_w = 1000; mon_max_w = 0;
        mon_min_gap = 1000; mon_busy = 0; mon_prev_low = 1'b0;
    endtask

    task automatic run_mon(input int n);
        logic low;
        repeat (n) begin
            cycle();
            low = !controls_n[7];
            if (low) begin
                if (!mon_prev_low) begin
                    mon_pulses++;
                    if (mon_pulses > 1 && mon_high_run < mon_min_gap) mon_min_gap = mon_high_run;
                end
                mon_low_run++;
            end else begin
                if (mon_prev_low) begin
                    if (mon_low_run < mon_min_w) mon_min_w = mon_low_run;
                    if (mon_low_run > mon_max_w) mon_max_w = mon_low_run;
                    mon_low_run = 0;
                    mon_high_run = 0;
                end
                mon_high_run++;
            end
            if (coin_busy) mon_busy++;
            mon_prev_low = low;
        end
    endtask

    typedef struct {
        logic [8:0] joy;
        logic       tsw;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int n;
        int base_total;
        int drops0;
        bit seen;

        vecs[0] = '{9'h010, 1'b0, 10'h3EF};
        vecs[1] = '{9'h003, 1'b0, 10'h3FF};
        vecs[2] = '{9'h00C, 1'b0, 10'h3FF};
        vecs[3] = '{9'h005, 1'b0, 10'h3FA};
        vecs[4] = '{9'h00F, 1'b0, 10'h3FF};
        vecs[5] = '{9'h028, 1'b0, 10'h3D7};
        vecs[6] = '{9'h140, 1'b0, 10'h1BF};
        vecs[7] = '{9'h000, 1'b1, 10'h2FF};
        vecs[8] = '{9'h002, 1'b0, 10'h3FD};
        vecs[9] = '{9'h00A, 1'b1, 10'h2F5};

        m_drops = 0;
        reset = 1'b1; joy_in = '0; test_sw = 1'b0;
        model_clear();
        repeat (3) @(negedge clk_sys);
        chk("reset_ctrl", 32'(controls_n), 32'h3FF);
        chk("reset_busy", 32'(coin_busy), 32'h0);
        chk("reset_total", 32'(coin_total), 32'h0);
        $display("reset: controls_n=%0h busy=%0b total=%0d", controls_n, coin_busy, coin_total);
        reset = 1'b0;

        // Shoot debounce latency
        joy_in = 9'h010;
        n = 0;
        do begin cycle(); n++; end while (controls_n[4] !== 1'b0 && n < 40);
        chk_range("shoot_latency", n, 2 * TD, 3 * TD + 3);
        $display("shoot: fell after %0d clocks", n);
        joy_in = '0;
        repeat (24) cycle();

        // One-tick glitch on right never reaches the output
        seen = 1'b0;
        joy_in = 9'h001;
        repeat (TD) begin cycle(); if (!controls_n[0]) seen = 1'b1; end
        joy_in = '0;
        repeat (30) begin cycle(); if (!controls_n[0]) seen = 1'b1; end
        chk("glitch_right", 32'(seen), 32'h0);
        $display("glitch: right seen low=%0b", seen);

        foreach (vecs[i]) begin
            joy_in = vecs[i].joy;
            test_sw = vecs[i].tsw;
            repeat (24) cycle();
            chk($sformatf("vec%0d", i), 32'(controls_n), 32'(vecs[i].exp));
            $display("vec%0d: joy=%03h test=%0b controls_n=%03h", i, joy_in, test_sw, controls_n);
        end
        joy_in = '0; test_sw = 1'b0;
        repeat (24) cycle();

        // Single long coin press
        base_total = int'(coin_total);
        mon_reset();
        joy_in = 9'h080;
        run_mon(20 * TD);
        joy_in = '0;
        run_mon(15 * TD);
        chk("coin1_pulses", 32'(mon_pulses), 32'd1);
        chk_range("coin1_width", mon_max_w, (CP - 1) * TD + 1, CP * TD);
        chk_range("coin1_busy", mon_busy, (CP + CG - 1) * TD + 1, (CP + CG) * TD);
        chk("coin1_total", 32'(int'(coin_total) - base_total), 32'd1);
        $display("coin1: pulses=%0d width=%0d busy=%0d total=%0d", mon_pulses, mon_max_w, mon_busy, coin_total);

        // Four presses, 3 ticks on / 3 ticks off
        base_total = int'(coin_total);
        mon_reset();
        repeat (4) begin
            joy_in = 9'h080; run_mon(3 * TD);
            joy_in = '0;     run_mon(3 * TD);
        end
        run_mon(30 * TD);
        chk("coin4_pulses", 32'(mon_pulses), 32'd4);
        chk_range("coin4_wmin", mon_min_w, (CP - 1) * TD + 1, CP * TD);
        chk_range("coin4_wmax", mon_max_w, (CP - 1) * TD + 1, CP * TD);
        chk_range("coin4_gap", mon_min_gap, CG * TD, 1000);
        chk("coin4_total", 32'(int'(coin_total) - base_total), 32'd4);
        $display("coin4: pulses=%0d w=%0d..%0d gap>=%0d total=%0d", mon_pulses, mon_min_w, mon_max_w, mon_min_gap, coin_total);

        // Fastest legal presses outrun the pulse train until pending saturates
        base_total = int'(coin_total);
        drops0 = m_drops;
        mon_reset();
        repeat (24) begin
            joy_in = 9'h080; run_mon(DT * TD);
            joy_in = '0;     run_mon(DT * TD);
        end
        run_mon(60 * TD);
        chk_range("drop_occurred", m_drops - drops0, 1, 23);
        chk("drop_pulses", 32'(mon_pulses), 32'(24 - (m_drops - drops0)));
        chk("drop_total", 32'(int'(coin_total) - base_total), 32'(24 - (m_drops - drops0)));
        $display("burst: presses=24 pulses=%0d dropped=%0d", mon_pulses, m_drops - drops0);

        // test_sw latency at two tick phases
        for (int k = 0; k < 2; k++) begin
            repeat (k + 1) cycle();
            test_sw = 1'b1;
            n = 0;
            do begin cycle(); n++; end while (controls_n[8] !== 1'b0 && n < 10);
            chk("test_latency", 32'(n), 32'd3);
            $display("test_sw: phase %0d fell after %0d clocks", k, n);
            test_sw = 1'b0;
            repeat (5) cycle();
        end

        // Reset in the middle of a coin pulse
        joy_in = 9'h080;
        n = 0;
        do begin cycle(); n++; end while (controls_n[7] !== 1'b0 && n < 40);
        chk("rst_pulse_seen", 32'(controls_n[7]), 32'h0);
        cycle();
        joy_in = '0;
        reset = 1'b1;
        #1;
        chk("rst_coin_high", 32'(controls_n[7]), 32'h1);
        chk("rst_busy_low", 32'(coin_busy), 32'h0);
        chk("rst_total", 32'(coin_total), 32'h0);
        @(negedge clk_sys);
        repeat (3) cycle();
        reset = 1'b0;
        mon_reset();
        run_mon(20 * TD);
        chk("rst_no_replay", 32'(mon_pulses), 32'd0);
        joy_in = 9'h080; run_mon(4 * TD);
        joy_in = '0;     run_mon(12 * TD);
        chk("rst_new_pulse", 32'(mon_pulses), 32'd1);
        chk("rst_new_total", 32'(coin_total), 32'd1);
        $display("reset-mid-pulse: replayed=0 new pulses=%0d total=%0d", mon_pulses, coin_total);

        // Randomized inputs, every cycle checked against the model
        for (int r = 0; r < 200; r++) begin
            joy_in = 9'($urandom) & 9'h17F;
            if ($urandom_range(0, 7) == 0) joy_in[7] = 1'b1;
            test_sw = 1'($urandom);
            repeat ($urandom_range(1, 16)) cycle();
        end
        $display("random: 200 segments done, total=%0d", coin_total);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
